// File: rtl/ga_sequencer.sv
// ga_sequencer: 16-state Johnson-counter master timing sequencer for the 40010 gate array.
// Drives S[7:0] plus the PHI_N, CCLK, RAS_N, READY and CPU_N decodes and the
// single-clk enables at the PHI_N edges. All decodes are taken from the next S value.
module ga_sequencer (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic       cen_16,
    input  logic       seq_load,
    input  logic [7:0] seq_val,
    output logic [7:0] S,
    output logic       PHI_N,
    output logic       CCLK,
    output logic       RAS_N,
    output logic       READY,
    output logic       CPU_N,
    output logic       cyc_start,
    output logic       phi_en_p,
    output logic       phi_en_n
);

    localparam int unsigned SW = 8;
    localparam int unsigned KW = 4;
    localparam int unsigned NK = 16;

    // Legal Johnson value for state index k: a run of ones filling from the bottom, then draining.
    function automatic logic [SW-1:0] johnson_val(input logic [KW-1:0] k);
        if (k <= KW'(8))
            return SW'((9'd1 << k) - 9'd1);
        else
            return 8'hFF << (k - KW'(8));
    endfunction

    // True when s is one of the 16 legal Johnson values.
    function automatic logic is_legal(input logic [SW-1:0] s);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NK; i++)
            if (s == johnson_val(KW'(i))) hit = 1'b1;
        return hit;
    endfunction

    // State index of s; any illegal value decodes as k=0.
    function automatic logic [KW-1:0] seq_index(input logic [SW-1:0] s);
        logic [KW-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < NK; i++)
            if (s == johnson_val(KW'(i))) k = KW'(i);
        return k;
    endfunction

    logic [SW-1:0] s_nxt;
    logic [KW-1:0] k_nxt;
    logic          upd;
    logic          phi_nxt;
    logic          cclk_nxt;
    logic          ras_n_nxt;
    logic          ready_nxt;
    logic          cpu_n_nxt;

    // Next sequencer value (load beats step, illegal state recovers to 00) and its decodes.
    always_comb begin
        upd       = seq_load | cen_16;
        s_nxt     = S;
        if (seq_load)
            s_nxt = seq_val;
        else if (cen_16)
            s_nxt = is_legal(S) ? {S[SW-2:0], ~S[SW-1]} : '0;
        k_nxt     = seq_index(s_nxt);
        phi_nxt   = k_nxt[0] ^ k_nxt[1];
        cclk_nxt  = (k_nxt >= KW'(3)) && (k_nxt <= KW'(10));
        ras_n_nxt = !(((k_nxt >= KW'(2))  && (k_nxt <= KW'(5))) ||
                      ((k_nxt >= KW'(10)) && (k_nxt <= KW'(13))));
        ready_nxt = (k_nxt >= KW'(12));
        cpu_n_nxt = ~k_nxt[KW-1];
    end

    // Sequencer, decode and pulse registers.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            S         <= '0;
            PHI_N     <= 1'b0;
            CCLK      <= 1'b0;
            RAS_N     <= 1'b1;
            READY     <= 1'b0;
            CPU_N     <= 1'b1;
            cyc_start <= 1'b0;
            phi_en_p  <= 1'b0;
            phi_en_n  <= 1'b0;
        end else begin
            S         <= s_nxt;
            PHI_N     <= phi_nxt;
            CCLK      <= cclk_nxt;
            RAS_N     <= ras_n_nxt;
            READY     <= ready_nxt;
            CPU_N     <= cpu_n_nxt;
            cyc_start <= upd && (s_nxt == '0);
            phi_en_p  <= upd && !PHI_N && phi_nxt;
            phi_en_n  <= upd && PHI_N && !phi_nxt;
        end
    end

endmodule

// File: tb/tb_ga_sequencer.sv
// Testbench for ga_sequencer: per-feature tasks checked against a table-driven state model.
module tb_ga_sequencer;

    logic       clk;
    logic       RESET_N;
    logic       cen_16;
    logic       seq_load;
    logic [7:0] seq_val;
    logic [7:0] S;
    logic       PHI_N, CCLK, RAS_N, READY, CPU_N;
    logic       cyc_start, phi_en_p, phi_en_n;

    int n_vec = 0;
    int n_err = 0;

    ga_sequencer dut (
        .clk(clk), .RESET_N(RESET_N), .cen_16(cen_16), .seq_load(seq_load), .seq_val(seq_val),
        .S(S), .PHI_N(PHI_N), .CCLK(CCLK), .RAS_N(RAS_N), .READY(READY), .CPU_N(CPU_N),
        .cyc_start(cyc_start), .phi_en_p(phi_en_p), .phi_en_n(phi_en_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Legal sequence, listed directly by state index.
    logic [7:0] seq_tab [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

    // {S, PHI_N, CCLK, RAS_N, READY, CPU_N, cyc_start, phi_en_p, phi_en_n}
    localparam logic [15:0] RST_V = {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000};

    logic [7:0]  m_s;
    logic        m_phi;
    logic [15:0] exp_v;
    logic [15:0] obs_v;

    assign obs_v = {S, PHI_N, CCLK, RAS_N, READY, CPU_N, cyc_start, phi_en_p, phi_en_n};

    // Index into the legal table, -1 if the value is not listed.
    function automatic int find_k(input logic [7:0] s);
        for (int i = 0; i < 16; i++)
            if (seq_tab[i] == s) return i;
        return -1;
    endfunction

    function automatic logic [15:0] model_vec(input logic [7:0] s, input logic cyc,
                                              input logic pp, input logic pn);
        int k;
        logic phi, cc, ras_n, rdy, cpu_n;
        k     = find_k(s);
        if (k < 0) k = 0;
        phi   = (k % 4 == 1) || (k % 4 == 2);
        cc    = (k >= 3) && (k <= 10);
        ras_n = !(((k >= 2) && (k <= 5)) || ((k >= 10) && (k <= 13)));
        rdy   = (k >= 12);
        cpu_n = (k <= 7);
        return {s, phi, cc, ras_n, rdy, cpu_n, cyc, pp, pn};
    endfunction

    task automatic model_reset();
        m_s   = 8'h00;
        m_phi = 1'b0;
        exp_v = RST_V;
    endtask

    // Apply one clk of stimulus and advance the model; returns 1 ns after the edge.
    task automatic drive(input logic cen, input logic ld, input logic [7:0] val);
        logic [7:0] ns;
        logic       upd, phi;
        int         k;
        cen_16   = cen;
        seq_load = ld;
        seq_val  = val;
        @(posedge clk);
        upd = cen | ld;
        if (ld)
            ns = val;
        else if (cen) begin
            k  = find_k(m_s);
            ns = (k < 0) ? 8'h00 : seq_tab[(k + 1) % 16];
        end else
            ns = m_s;
        exp_v = model_vec(ns, 1'b0, 1'b0, 1'b0);
        phi   = exp_v[7];
        exp_v[2] = upd && (ns == 8'h00);
        exp_v[1] = upd && !m_phi && phi;
        exp_v[0] = upd && m_phi && !phi;
        m_s   = ns;
        m_phi = phi;
        #1;
        cen_16   = 1'b0;
        seq_load = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; cen_16 = 1'b0; seq_load = 1'b0; seq_val = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (obs_v !== RST_V) begin
            n_err++;
            $display("FAIL reset: got %h want %h", obs_v, RST_V);
        end
        RESET_N = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        n_vec++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL reset_idle: got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_slow_step();
        int cyc_cnt;
        cyc_cnt = 0;
        for (int st = 0; st < 40; st++) begin
            for (int c = 0; c < 4; c++) begin
                drive(c == 0, 1'b0, 8'h00);
                if (cyc_start === 1'b1) cyc_cnt++;
                n_vec++;
                if (obs_v !== exp_v) begin
                    n_err++;
                    $display("FAIL slow_step st=%0d c=%0d: got %h want %h", st, c, obs_v, exp_v);
                end
            end
        end
        n_vec++;
        if (cyc_cnt != 2) begin
            n_err++;
            $display("FAIL slow_cyc_count: got %0d want 2", cyc_cnt);
        end
    endtask

    task automatic test_continuous();
        int k;
        for (int st = 0; st < 32; st++) begin
            drive(1'b1, 1'b0, 8'h00);
            k = find_k(m_s);
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL continuous st=%0d: got %h want %h", st, obs_v, exp_v);
            end
            n_vec++;
            if (phi_en_p !== (k % 4 == 1) || phi_en_n !== (k % 4 == 3)) begin
                n_err++;
                $display("FAIL continuous_phi_en k=%0d: got p=%b n=%b want p=%b n=%b",
                         k, phi_en_p, phi_en_n, (k % 4 == 1), (k % 4 == 3));
            end
        end
    endtask

    task automatic test_illegal_load();
        drive(1'b0, 1'b1, 8'h55);
        n_vec++;
        if (obs_v !== exp_v || S !== 8'h55 || CPU_N !== 1'b1 || PHI_N !== 1'b0) begin
            n_err++;
            $display("FAIL illegal_load: got %h want %h", obs_v, exp_v);
        end
        drive(1'b0, 1'b0, 8'h00);
        n_vec++;
        if (S !== 8'h55) begin
            n_err++;
            $display("FAIL illegal_hold: got %h want 55", S);
        end
        drive(1'b1, 1'b0, 8'h00);
        n_vec++;
        if (obs_v !== exp_v || S !== 8'h00) begin
            n_err++;
            $display("FAIL illegal_recover: got %h want %h", obs_v, exp_v);
        end
        drive(1'b1, 1'b0, 8'h00);
        n_vec++;
        if (S !== 8'h01) begin
            n_err++;
            $display("FAIL illegal_next: got %h want 01", S);
        end
    endtask

    task automatic test_load_priority();
        drive(1'b1, 1'b1, 8'h0F);
        n_vec++;
        if (obs_v !== exp_v || S !== 8'h0F || PHI_N !== 1'b0 || CCLK !== 1'b1 || RAS_N !== 1'b0) begin
            n_err++;
            $display("FAIL load_priority: got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 8'hFC);
        n_vec++;
        if (obs_v !== exp_v) begin
            n_err++;
            $display("FAIL areset_setup: got %h want %h", obs_v, exp_v);
        end
        #2 RESET_N = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (obs_v !== RST_V) begin
            n_err++;
            $display("FAIL areset_immediate: got %h want %h", obs_v, RST_V);
        end
        repeat (2) @(posedge clk);
        #3 RESET_N = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 8'h00);
        n_vec++;
        if (obs_v !== exp_v || S !== 8'h01) begin
            n_err++;
            $display("FAIL areset_first_step: got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_wrap_load();
        drive(1'b0, 1'b1, 8'h80);
        n_vec++;
        if (obs_v !== exp_v || CPU_N !== 1'b0 || READY !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_load: got %h want %h", obs_v, exp_v);
        end
        drive(1'b1, 1'b0, 8'h00);
        n_vec++;
        if (obs_v !== exp_v || S !== 8'h00 || cyc_start !== 1'b1 || CPU_N !== 1'b1 || READY !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_step: got %h want %h", obs_v, exp_v);
        end
        drive(1'b0, 1'b0, 8'h00);
        n_vec++;
        if (obs_v !== exp_v || cyc_start !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_pulse_len: got %h want %h", obs_v, exp_v);
        end
        drive(1'b0, 1'b1, 8'h00);
        n_vec++;
        if (cyc_start !== 1'b1) begin
            n_err++;
            $display("FAIL reload_zero_cyc: got %b want 1", cyc_start);
        end
    endtask

    task automatic test_random();
        logic       cen, ld;
        logic [7:0] val;
        for (int i = 0; i < 400; i++) begin
            cen = 1'($urandom_range(0, 1));
            ld  = ($urandom_range(0, 7) == 0);
            val = ($urandom_range(0, 3) == 0) ? 8'($urandom) : seq_tab[$urandom_range(0, 15)];
            drive(cen, ld, val);
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++;
                $display("FAIL random i=%0d cen=%b ld=%b val=%h: got %h want %h",
                         i, cen, ld, val, obs_v, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_slow_step();
        test_continuous();
        test_illegal_load();
        test_load_priority();
        test_async_reset();
        test_wrap_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
